// File: rtl/stack_guard_nested.sv
// Nested UCC stack-protection monitor: a shadow stack of frame base pointers
// confines writes to the innermost frame and raises a registered reset on misuse.
module stack_guard_nested #(
  parameter int AW = 16,
  parameter int DEPTH = 4,
  parameter logic [AW-1:0] RESET_HANDLER = '0
) (
  input  logic                         clk,
  input  logic                         system_reset,
  input  logic [AW-1:0]                pc,
  input  logic [AW-1:0]                data_addr,
  input  logic                         data_wr,
  input  logic [AW-1:0]                stack_pointer,
  input  logic                         inst_changed,
  input  logic                         ucc_enter,
  input  logic                         ucc_exit,
  output logic                         reset,
  output logic [AW-1:0]                base_pointer,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic [2:0]                   viol_cause
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {NOT_UCC, IN_UCC, RST} state_t;

  state_t        state;
  logic [AW-1:0] stack [DEPTH];
  logic [IW-1:0] top_idx;
  logic [IW-1:0] push_idx;
  logic          enter_eff;
  logic          exit_eff;
  logic          conflict;
  logic          recover;
  logic [2:0]    code;

  assign top_idx      = IW'(depth - DW'(1));
  assign push_idx     = IW'(depth);
  assign base_pointer = (depth == '0) ? '0 : stack[top_idx];
  assign enter_eff    = inst_changed & ucc_enter;
  assign exit_eff     = inst_changed & ucc_exit;
  assign conflict     = enter_eff & exit_eff;
  assign recover      = (pc == RESET_HANDLER) && !data_wr && !conflict;

  // Checks are ordered by cause code so the lowest code wins when several coincide.
  always_comb begin
    code = 3'd0;
    if (state == IN_UCC) begin
      if (data_wr && (data_addr >= base_pointer))
        code = 3'd1;
      else if (exit_eff && (stack_pointer != base_pointer))
        code = 3'd2;
      else if (enter_eff && (depth == DW'(DEPTH)))
        code = 3'd3;
      else if (conflict)
        code = 3'd5;
    end else if (state == NOT_UCC) begin
      if (exit_eff)
        code = 3'd4;
      else if (conflict)
        code = 3'd5;
    end
  end

  always_ff @(posedge clk) begin
    if (system_reset) begin
      state      <= RST;
      reset      <= 1'b1;
      depth      <= '0;
      viol_cause <= 3'd0;
      for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
    end else if (code != 3'd0) begin
      state <= RST;
      reset <= 1'b1;
      depth <= '0;
      for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
      if (viol_cause == 3'd0) viol_cause <= code;
    end else begin
      case (state)
        NOT_UCC: begin
          if (enter_eff) begin
            stack[0] <= stack_pointer;
            depth    <= DW'(1);
            state    <= IN_UCC;
          end
        end
        IN_UCC: begin
          if (enter_eff) begin
            stack[push_idx] <= stack_pointer;
            depth           <= depth + DW'(1);
          end else if (exit_eff) begin
            depth <= depth - DW'(1);
            if (depth == DW'(1)) state <= NOT_UCC;
          end
        end
        RST: begin
          if (recover) begin
            reset      <= 1'b0;
            viol_cause <= 3'd0;
            if (enter_eff) begin
              stack[0] <= stack_pointer;
              depth    <= DW'(1);
              state    <= IN_UCC;
            end else begin
              state <= NOT_UCC;
            end
          end else if (viol_cause == 3'd0) begin
            viol_cause <= conflict ? 3'd5 : 3'd6;
          end
        end
        default: begin
          state <= RST;
          reset <= 1'b1;
          depth <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_guard_nested.sv
// Self-checking bench for stack_guard_nested: directed vector table, hand sequences
// for overflow and mid-operation reset, then random traffic against a queue-based model.
module tb_stack_guard_nested;

  logic        clk;
  logic        system_reset;
  logic [15:0] pc;
  logic [15:0] data_addr;
  logic        data_wr;
  logic [15:0] stack_pointer;
  logic        inst_changed;
  logic        ucc_enter;
  logic        ucc_exit;
  logic        reset;
  logic [15:0] base_pointer;
  logic [2:0]  depth;
  logic [2:0]  viol_cause;

  int total_checks = 0;
  int passed_checks = 0;

  stack_guard_nested #(.AW(16), .DEPTH(4), .RESET_HANDLER(16'h0000)) dut (
    .clk(clk),
    .system_reset(system_reset),
    .pc(pc),
    .data_addr(data_addr),
    .data_wr(data_wr),
    .stack_pointer(stack_pointer),
    .inst_changed(inst_changed),
    .ucc_enter(ucc_enter),
    .ucc_exit(ucc_exit),
    .reset(reset),
    .base_pointer(base_pointer),
    .depth(depth),
    .viol_cause(viol_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of frame bases, a "held in reset" flag and the sticky cause.
  bit          m_rst;
  logic [15:0] m_stk[$];
  int          m_cause;

  function automatic void modelStep(bit rst, logic [15:0] p, logic [15:0] a, bit wr,
                                    logic [15:0] sp, bit ic, bit en, bit ex);
    bit eff_en = ic && en;
    bit eff_ex = ic && ex;
    int cands[$];
    int best;
    if (rst) begin
      m_rst = 1;
      m_stk.delete();
      m_cause = 0;
      return;
    end
    if (m_rst) begin
      if (p == 16'h0000 && !wr && !(eff_en && eff_ex)) begin
        m_rst = 0;
        m_cause = 0;
        if (eff_en) m_stk.push_back(sp);
      end else if (m_cause == 0) begin
        m_cause = (eff_en && eff_ex) ? 5 : 6;
      end
      return;
    end
    if (m_stk.size() == 0) begin
      if (eff_ex) cands.push_back(4);
    end else begin
      if (wr && a >= m_stk[$]) cands.push_back(1);
      if (eff_ex && sp != m_stk[$]) cands.push_back(2);
      if (eff_en && m_stk.size() == 4) cands.push_back(3);
    end
    if (eff_en && eff_ex) cands.push_back(5);
    if (cands.size() != 0) begin
      best = cands.min()[0];
      m_rst = 1;
      m_stk.delete();
      if (m_cause == 0) m_cause = best;
    end else if (eff_en) begin
      m_stk.push_back(sp);
    end else if (eff_ex) begin
      void'(m_stk.pop_back());
    end
  endfunction

  task automatic applyStimulus(input bit rst, input logic [15:0] p, input logic [15:0] a,
                               input bit wr, input logic [15:0] sp, input bit ic,
                               input bit en, input bit ex);
    system_reset  = rst;
    pc            = p;
    data_addr     = a;
    data_wr       = wr;
    stack_pointer = sp;
    inst_changed  = ic;
    ucc_enter     = en;
    ucc_exit      = ex;
    @(posedge clk);
    modelStep(rst, p, a, wr, sp, ic, en, ex);
    #1;
  endtask

  task automatic checkOutput(input string name, input bit er, input logic [2:0] ed,
                             input logic [15:0] eb, input logic [2:0] ec);
    total_checks++;
    if (reset === er && depth === ed && base_pointer === eb && viol_cause === ec) begin
      passed_checks++;
    end else begin
      $display("[TB] FAIL %s: got reset=%0b depth=%0d bp=%h cause=%0d, expected reset=%0b depth=%0d bp=%h cause=%0d",
               name, reset, depth, base_pointer, viol_cause, er, ed, eb, ec);
    end
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, m_rst, 3'(m_stk.size()),
                (m_stk.size() == 0) ? 16'h0000 : m_stk[$], 3'(m_cause));
  endtask

  typedef struct {
    bit          rst;
    logic [15:0] p;
    logic [15:0] a;
    bit          wr;
    logic [15:0] sp;
    bit          ic;
    bit          en;
    bit          ex;
    bit          er;
    logic [2:0]  ed;
    logic [15:0] eb;
    logic [2:0]  ec;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, logic [15:0] p, logic [15:0] a, bit wr,
                              logic [15:0] sp, bit ic, bit en, bit ex,
                              bit er, logic [2:0] ed, logic [15:0] eb, logic [2:0] ec);
    vec_t v;
    v.rst = rst; v.p = p; v.a = a; v.wr = wr; v.sp = sp; v.ic = ic; v.en = en; v.ex = ex;
    v.er = er; v.ed = ed; v.eb = eb; v.ec = ec;
    return v;
  endfunction

  logic [15:0] r_pc, r_addr, r_sp;
  bit          r_rst, r_wr, r_ic, r_en, r_ex;

  initial begin
    // rst, pc, addr, wr, sp, ic, en, ex  ->  reset, depth, bp, cause
    vecs.push_back(mk(1, 16'h0040, 16'h0, 0, 16'h0,    0, 0, 0,  1, 0, 16'h0,    0));
    vecs.push_back(mk(0, 16'h0040, 16'h0, 0, 16'h0,    0, 0, 0,  1, 0, 16'h0,    6));
    vecs.push_back(mk(0, 16'h0040, 16'h0, 0, 16'h0,    0, 0, 0,  1, 0, 16'h0,    6));
    vecs.push_back(mk(0, 16'h0040, 16'h0, 0, 16'h0,    0, 0, 0,  1, 0, 16'h0,    6));
    vecs.push_back(mk(0, 16'h0000, 16'h0, 0, 16'h0,    0, 0, 0,  0, 0, 16'h0,    0));
    vecs.push_back(mk(0, 16'h0100, 16'h0, 0, 16'h0400, 1, 1, 0,  0, 1, 16'h0400, 0));
    vecs.push_back(mk(0, 16'h0100, 16'h03FE, 1, 16'h0400, 0, 0, 0, 0, 1, 16'h0400, 0));
    vecs.push_back(mk(0, 16'h0100, 16'h0400, 1, 16'h0400, 0, 0, 0, 1, 0, 16'h0,    1));
    vecs.push_back(mk(0, 16'h0000, 16'h0, 0, 16'h0,    0, 0, 0,  0, 0, 16'h0,    0));
    vecs.push_back(mk(0, 16'h0100, 16'h0, 0, 16'h0400, 1, 1, 0,  0, 1, 16'h0400, 0));
    vecs.push_back(mk(0, 16'h0100, 16'h0, 0, 16'h0380, 1, 1, 0,  0, 2, 16'h0380, 0));
    vecs.push_back(mk(0, 16'h0100, 16'h0390, 1, 16'h0380, 0, 0, 0, 1, 0, 16'h0,    1));
    vecs.push_back(mk(0, 16'h0000, 16'h0, 0, 16'h0,    0, 0, 0,  0, 0, 16'h0,    0));
    vecs.push_back(mk(0, 16'h0100, 16'h0, 0, 16'h0400, 1, 1, 0,  0, 1, 16'h0400, 0));
    vecs.push_back(mk(0, 16'h0100, 16'h0, 0, 16'h0380, 1, 1, 0,  0, 2, 16'h0380, 0));
    vecs.push_back(mk(0, 16'h0100, 16'h0, 0, 16'h0380, 1, 0, 1,  0, 1, 16'h0400, 0));
    vecs.push_back(mk(0, 16'h0100, 16'h0, 0, 16'h0400, 1, 0, 1,  0, 0, 16'h0,    0));
    vecs.push_back(mk(0, 16'h0100, 16'hFFFF, 1, 16'h0, 0, 0, 0,  0, 0, 16'h0,    0));
    vecs.push_back(mk(0, 16'h0100, 16'h0, 0, 16'h0400, 1, 0, 1,  1, 0, 16'h0,    4));
    vecs.push_back(mk(0, 16'h0000, 16'h0, 0, 16'h0,    0, 0, 0,  0, 0, 16'h0,    0));
    vecs.push_back(mk(0, 16'h0100, 16'h0, 0, 16'h0400, 1, 1, 0,  0, 1, 16'h0400, 0));
    vecs.push_back(mk(0, 16'h0100, 16'h0, 0, 16'h03FC, 1, 0, 1,  1, 0, 16'h0,    2));
    vecs.push_back(mk(0, 16'h0000, 16'h0, 0, 16'h0,    0, 0, 0,  0, 0, 16'h0,    0));
    vecs.push_back(mk(0, 16'h0100, 16'h0, 0, 16'h0400, 0, 1, 1,  0, 0, 16'h0,    0));
    vecs.push_back(mk(0, 16'h0100, 16'h0, 0, 16'h0400, 1, 1, 0,  0, 1, 16'h0400, 0));
    vecs.push_back(mk(0, 16'h0100, 16'h0, 0, 16'h0400, 0, 1, 1,  0, 1, 16'h0400, 0));
    vecs.push_back(mk(0, 16'h0100, 16'h0, 0, 16'h0400, 1, 1, 1,  1, 0, 16'h0,    5));
    vecs.push_back(mk(0, 16'h0000, 16'h0, 1, 16'h0,    0, 0, 0,  1, 0, 16'h0,    5));
    vecs.push_back(mk(0, 16'h0000, 16'h0, 0, 16'h0200, 1, 1, 0,  0, 1, 16'h0200, 0));
    vecs.push_back(mk(0, 16'h0100, 16'h0300, 1, 16'h01FC, 1, 0, 1, 1, 0, 16'h0,   1));
    vecs.push_back(mk(0, 16'h0000, 16'h0, 0, 16'h0,    0, 0, 0,  0, 0, 16'h0,    0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].p, vecs[i].a, vecs[i].wr, vecs[i].sp,
                    vecs[i].ic, vecs[i].en, vecs[i].ex);
      checkOutput($sformatf("vec%0d", i), vecs[i].er, vecs[i].ed, vecs[i].eb, vecs[i].ec);
    end

    // Fill the shadow stack to DEPTH, then one more enter must overflow.
    applyStimulus(0, 16'h0100, 16'h0, 0, 16'h0400, 1, 1, 0);
    applyStimulus(0, 16'h0100, 16'h0, 0, 16'h03C0, 1, 1, 0);
    applyStimulus(0, 16'h0100, 16'h0, 0, 16'h0380, 1, 1, 0);
    applyStimulus(0, 16'h0100, 16'h0, 0, 16'h0340, 1, 1, 0);
    checkOutput("full_depth", 0, 3'd4, 16'h0340, 3'd0);
    applyStimulus(0, 16'h0100, 16'h0, 0, 16'h0300, 1, 1, 0);
    checkOutput("overflow", 1, 3'd0, 16'h0000, 3'd3);
    applyStimulus(0, 16'h0000, 16'h0, 0, 16'h0, 0, 0, 0);
    checkOutput("overflow_recover", 0, 3'd0, 16'h0000, 3'd0);

    // System reset while three frames deep.
    applyStimulus(0, 16'h0100, 16'h0, 0, 16'h0400, 1, 1, 0);
    applyStimulus(0, 16'h0100, 16'h0, 0, 16'h03C0, 1, 1, 0);
    applyStimulus(0, 16'h0100, 16'h0, 0, 16'h0380, 1, 1, 0);
    checkOutput("depth3", 0, 3'd3, 16'h0380, 3'd0);
    applyStimulus(1, 16'h0100, 16'h0, 0, 16'h0380, 0, 0, 0);
    checkOutput("mid_reset", 1, 3'd0, 16'h0000, 3'd0);
    applyStimulus(0, 16'h0100, 16'h0, 0, 16'h0, 0, 0, 0);
    checkOutput("mid_reset_hold", 1, 3'd0, 16'h0000, 3'd6);
    applyStimulus(0, 16'h0000, 16'h0, 0, 16'h0, 0, 0, 0);
    checkOutput("mid_reset_recover", 0, 3'd0, 16'h0000, 3'd0);

    for (int i = 0; i < 800; i++) begin
      r_rst  = ($urandom_range(0, 79) == 0);
      r_pc   = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'(16'h0100 + $urandom_range(0, 255));
      r_wr   = ($urandom_range(0, 7) == 0);
      r_addr = 16'($urandom_range(16'h0300, 16'h04FF));
      r_ic   = ($urandom_range(0, 3) != 0);
      r_en   = ($urandom_range(0, 2) == 0);
      r_ex   = ($urandom_range(0, 3) == 0);
      if (m_stk.size() > 0 && $urandom_range(0, 3) != 0)
        r_sp = m_stk[$];
      else
        r_sp = 16'($urandom_range(16'h0300, 16'h04FF));
      applyStimulus(r_rst, r_pc, r_addr, r_wr, r_sp, r_ic, r_en, r_ex);
      checkModel($sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
